// File: rtl/rr_arbiter_mux_4_1.sv
// Round-robin arbiter for four valid/ready requesters feeding one registered
// output stage. The grant indexes a 4:1 data mux; the chosen word, its source
// index and a valid flag are held in the output register until the consumer
// takes them.
module rr_arbiter_mux_4_1 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    logic [1:0]       last_grant_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [1:0]       out_sel_q;

    logic             can_load;
    logic             grant_found;
    logic [1:0]       grant;
    logic [WIDTH-1:0] mux_data;
    logic             in_xfer;
    logic             out_xfer;

    // A held word that is leaving this cycle frees the stage, so loads keep full rate.
    assign can_load = !out_valid_q || out_ready;

    // Rotating priority search starting one past the last granted requester.
    always_comb begin
        logic [1:0] idx;
        grant       = 2'd0;
        grant_found = 1'b0;
        idx         = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant_q + 2'(k);
            if (!grant_found && in_valid[idx]) begin
                grant       = idx;
                grant_found = 1'b1;
            end
        end
    end

    // One-hot ready only when a request wins and the output stage can accept it.
    always_comb begin
        in_ready = 4'b0000;
        if (!rst && can_load && grant_found) begin
            in_ready = 4'b0001 << grant;
        end
    end

    // 4:1 data mux driven by the grant index.
    always_comb begin
        mux_data = in_data0;
        unique case (grant)
            2'd0: mux_data = in_data0;
            2'd1: mux_data = in_data1;
            2'd2: mux_data = in_data2;
            2'd3: mux_data = in_data3;
            default: mux_data = in_data0;
        endcase
    end

    assign in_xfer  = |(in_valid & in_ready);
    assign out_xfer = out_valid_q && out_ready;

    // Output stage and priority pointer; pointer moves only on an accepted input.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 2'd3;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sel_q    <= 2'd0;
        end else if (in_xfer) begin
            last_grant_q <= grant;
            out_valid_q  <= 1'b1;
            out_data_q   <= mux_data;
            out_sel_q    <= grant;
        end else if (out_xfer) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arbiter_mux_4_1.sv
// Directed bench for rr_arbiter_mux_4_1: a vector table walked cycle by cycle,
// then a hold/drop sequence and a pseudo-random run against a small model.
module tb_rr_arbiter_mux_4_1;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter_mux_4_1 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data0 (in_data0),
        .in_data1 (in_data1),
        .in_data2 (in_data2),
        .in_data3 (in_data3),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic [3:0]       iv;
        logic [WIDTH-1:0] d0, d1, d2, d3;
        logic             ordy;
        logic [3:0]       exp_ready;  // before the edge
        logic             exp_ov;     // after the edge
        logic [WIDTH-1:0] exp_od;
        logic [1:0]       exp_os;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] iv, input logic [WIDTH-1:0] d0,
                       input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                       input logic [WIDTH-1:0] d3, input logic ordy, input logic [3:0] er,
                       input logic eov, input logic [WIDTH-1:0] eod, input logic [1:0] eos);
        vec_t v;
        v.rst = r; v.iv = iv; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.ordy = ordy;
        v.exp_ready = er; v.exp_ov = eov; v.exp_od = eod; v.exp_os = eos;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] iv, input logic [WIDTH-1:0] d0,
                         input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                         input logic [WIDTH-1:0] d3, input logic ordy);
        rst = r; in_valid = iv; in_data0 = d0; in_data1 = d1; in_data2 = d2; in_data3 = d3;
        out_ready = ordy;
    endtask

    // Independent reference for the random phase.
    logic [1:0]       m_lg;
    logic             m_ov;
    logic [WIDTH-1:0] m_od;
    logic [1:0]       m_os;

    function automatic logic [3:0] ref_ready(input logic [3:0] iv, input logic [1:0] lg,
                                             input logic ov, input logic ordy);
        logic [1:0] i;
        if (ov && !ordy) return 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            i = lg + 2'(k);
            if (iv[i]) return 4'b0001 << i;
        end
        return 4'b0000;
    endfunction

    initial begin
        logic [3:0] er;
        logic [WIDTH-1:0] dsel;
        drive(1'b1, 4'b0000, '0, '0, '0, '0, 1'b0);

        // Reset with requests present and consumer ready: nothing granted.
        add(1, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0000, 0, 4'h0, 2'd0);
        add(1, 4'b0000, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0000, 0, 4'h0, 2'd0);
        // All requesting: rotation 0,1,2,3,0.
        add(0, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0001, 1, 4'hA, 2'd0);
        add(0, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0010, 1, 4'hB, 2'd1);
        add(0, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0100, 1, 4'hC, 2'd2);
        add(0, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b1000, 1, 4'hD, 2'd3);
        add(0, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0001, 1, 4'hA, 2'd0);
        // Single requester granted every cycle.
        for (int i = 0; i < 4; i++)
            add(0, 4'b0100, 4'hA, 4'hB, 4'h5, 4'hD, 1, 4'b0100, 1, 4'h5, 2'd2);
        // Backpressure: load 7 from requester 1, then hold three cycles.
        add(0, 4'b0010, 4'hA, 4'h7, 4'hC, 4'hD, 1, 4'b0010, 1, 4'h7, 2'd1);
        for (int i = 0; i < 3; i++)
            add(0, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 0, 4'b0000, 1, 4'h7, 2'd1);
        add(0, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0100, 1, 4'hC, 2'd2);
        // Sparse traffic wrapping past pointer 3.
        add(0, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b1000, 1, 4'hD, 2'd3);
        add(0, 4'b0011, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0001, 1, 4'hA, 2'd0);
        add(0, 4'b0011, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0010, 1, 4'hB, 2'd1);
        // No requests: output drains, data and sel hold.
        add(0, 4'b0000, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0000, 0, 4'hB, 2'd1);
        add(0, 4'b0000, 4'hA, 4'hB, 4'hC, 4'hD, 0, 4'b0000, 0, 4'hB, 2'd1);
        // Reset while a word is held.
        add(0, 4'b0001, 4'hA, 4'hB, 4'hC, 4'hD, 0, 4'b0001, 1, 4'hA, 2'd0);
        add(0, 4'b0000, 4'hA, 4'hB, 4'hC, 4'hD, 0, 4'b0000, 1, 4'hA, 2'd0);
        add(1, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 0, 4'b0000, 0, 4'h0, 2'd0);
        add(0, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0001, 1, 4'hA, 2'd0);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3,
                  vecs[i].ordy);
            #1;
            check("in_ready", i, 32'(in_ready), 32'(vecs[i].exp_ready));
            @(posedge clk); #1;
            check("out_valid", i, 32'(out_valid), 32'(vecs[i].exp_ov));
            check("out_data", i, 32'(out_data), 32'(vecs[i].exp_od));
            check("out_sel", i, 32'(out_sel), 32'(vecs[i].exp_os));
        end
        // State now: out_valid=1, data A, sel 0, pointer 0.

        // Hold with requester 3, which drops before being served; then 2 alone wins.
        drive(0, 4'b1000, 4'h1, 4'h2, 4'h3, 4'h4, 0); #1;
        check("hold_ready", 0, 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        check("hold_data", 0, 32'(out_data), 32'hA);
        drive(0, 4'b0100, 4'h1, 4'h2, 4'h3, 4'h4, 1); #1;
        check("drop_ready", 0, 32'(in_ready), 32'b0100);
        @(posedge clk); #1;
        check("drop_data", 0, 32'(out_data), 32'h3);
        check("drop_sel", 0, 32'(out_sel), 32'd2);

        // Pseudo-random run against the reference model; pointer is 2 here.
        m_lg = 2'd2; m_ov = 1'b1; m_od = 4'h3; m_os = 2'd2;
        for (int c = 0; c < 60; c++) begin
            drive(0, 4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
                  4'($urandom), 1'($urandom_range(0, 3) != 0));
            er = ref_ready(in_valid, m_lg, m_ov, out_ready);
            #1;
            check("rand_ready", c, 32'(in_ready), 32'(er));
            if (er != 4'b0000) begin
                unique case (er)
                    4'b0001: begin dsel = in_data0; m_os = 2'd0; end
                    4'b0010: begin dsel = in_data1; m_os = 2'd1; end
                    4'b0100: begin dsel = in_data2; m_os = 2'd2; end
                    default: begin dsel = in_data3; m_os = 2'd3; end
                endcase
                m_od = dsel; m_lg = m_os; m_ov = 1'b1;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            @(posedge clk); #1;
            check("rand_valid", c, 32'(out_valid), 32'(m_ov));
            check("rand_data", c, 32'(out_data), 32'(m_od));
            check("rand_sel", c, 32'(out_sel), 32'(m_os));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
